// File: rtl/dmem_arbiter.sv
// Data memory arbiter: CPU has fixed priority, host gets idle cycles,
// and a starvation counter forces a one-cycle CPU stall for the host.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_re,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wr_data,
    output logic [31:0]       cpu_rd_data,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_rd,
    input  logic [3:0]        host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wr_data,
    output logic              host_ack,
    output logic              host_rd_valid,
    output logic [31:0]       host_rd_data,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_rd_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] FORCE = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] cnt_nxt;
    logic [7:0] cnt_inc;
    logic       last_host_rd;
    logic       cpu_active;
    logic       in_force;
    logic       grant;

    assign cpu_active = cpu_re | (|cpu_we);
    assign in_force   = (state == FORCE);
    assign grant      = in_force | (host_req & ~cpu_active);
    assign cnt_inc    = wait_cnt + 8'd1;

    // Any grant, withdrawal or idle cycle lands back in IDLE
    always_comb begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
        if (!in_force && host_req && cpu_active) begin
            cnt_nxt   = cnt_inc;
            state_nxt = (cnt_inc == 8'(STARVE_LIMIT)) ? FORCE : WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            last_host_rd <= 1'b0;
            cpu_stall    <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= cnt_nxt;
            last_host_rd <= grant & host_rd;
            cpu_stall    <= (state_nxt == FORCE);
        end
    end

    always_comb begin
        host_ack    = 1'b0;
        mem_we      = 4'd0;
        mem_addr    = cpu_addr;
        mem_wr_data = cpu_wr_data;
        if (rst_n) begin
            if (grant) begin
                host_ack    = 1'b1;
                mem_addr    = host_addr;
                mem_wr_data = host_wr_data;
                mem_we      = host_rd ? 4'd0 : host_we;
            end else begin
                mem_we = cpu_we;
            end
        end
    end

    assign host_rd_valid = last_host_rd;
    assign host_rd_data  = last_host_rd ? mem_rd_data : 32'd0;
    assign cpu_rd_data   = mem_rd_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural
// arbitration/memory model and a bench-side synchronous bank model.
module tb_dmem_arbiter;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_re;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic [31:0] cpu_rd_data;
    logic        cpu_stall;
    logic        host_req;
    logic        host_rd;
    logic [3:0]  host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wr_data;
    logic        host_ack;
    logic        host_rd_valid;
    logic [31:0] host_rd_data;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    dmem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_re       (cpu_re),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_rd_data  (cpu_rd_data),
        .cpu_stall    (cpu_stall),
        .host_req     (host_req),
        .host_rd      (host_rd),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wr_data (host_wr_data),
        .host_ack     (host_ack),
        .host_rd_valid(host_rd_valid),
        .host_rd_data (host_rd_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data)
    );

    always #5 clk = ~clk;

    // Bank model driven by the DUT: byte-lane writes, registered read
    logic [31:0] bank [256];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we[i])
                bank[mem_addr[9:2]][i*8 +: 8] <= mem_wr_data[i*8 +: 8];
        mem_rd_data <= bank[mem_addr[9:2]];
    end

    typedef struct {
        logic        ack;
        logic        stall;
        logic [3:0]  we;
        logic        chk;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdv;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: memory contents and starvation bookkeeping
    logic [31:0] ref_mem [256];
    int          denied   = 0;
    bit          forced   = 0;
    bit          pend_rd  = 0;
    logic [31:0] pend_dat = 0;
    bit          g_last   = 0;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw,
                                          logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    task automatic tick();
        exp_t e;
        bit   act;
        e = '{default: '0};
        e.rdv = pend_rd && rst_n;
        if (e.rdv) rd_q.push_back(pend_dat);
        pend_rd = 0;
        g_last  = 0;
        if (!rst_n) begin
            denied = 0;
            forced = 0;
        end else begin
            act     = cpu_re || (cpu_we != 0);
            e.stall = forced;
            e.chk   = 1;
            if (forced || (host_req && !act)) begin
                g_last = 1;
                e.ack  = 1;
                e.addr = host_addr;
                e.wd   = host_wr_data;
                e.we   = host_rd ? 4'd0 : host_we;
                if (host_rd) begin
                    pend_rd  = 1;
                    pend_dat = ref_mem[host_addr[9:2]];
                end else begin
                    ref_mem[host_addr[9:2]] =
                        merge(ref_mem[host_addr[9:2]], host_wr_data, host_we);
                end
                denied = 0;
                forced = 0;
            end else begin
                e.addr = cpu_addr;
                e.wd   = cpu_wr_data;
                e.we   = cpu_we;
                ref_mem[cpu_addr[9:2]] =
                    merge(ref_mem[cpu_addr[9:2]], cpu_wr_data, cpu_we);
                if (host_req) begin
                    denied++;
                    if (denied == LIMIT) forced = 1;
                end else begin
                    denied = 0;
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("host_ack", 32'(host_ack), 32'(e.ack));
            chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            if (e.chk) begin
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_wr_data", mem_wr_data, e.wd);
            end
            chk("host_rd_valid", 32'(host_rd_valid), 32'(e.rdv));
            if (host_rd_valid && rd_q.size() != 0)
                chk("host_rd_data", host_rd_data, rd_q.pop_front());
            else if (!host_rd_valid)
                chk("host_rd_data_idle", host_rd_data, 32'd0);
        end
    end

    task automatic host_set(bit rd, logic [3:0] we, logic [31:0] a,
                            logic [31:0] d);
        host_req     = 1;
        host_rd      = rd;
        host_we      = we;
        host_addr    = a;
        host_wr_data = d;
    endtask

    task automatic tick_host();
        tick();
        if (g_last) host_req = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            bank[i]    = 32'd0;
            ref_mem[i] = 32'd0;
        end
        mem_rd_data = 0;
        rst_n = 0;
        cpu_re = 0; cpu_we = 4'hF; cpu_addr = 0; cpu_wr_data = 0;
        host_set(1'b0, 4'hF, 32'h4, 32'h1);
        @(posedge clk);
        #1;
        tick();
        tick();

        rst_n = 1;
        host_req = 0;
        cpu_addr = 32'h40; cpu_wr_data = 32'hDEADBEEF;
        tick();
        cpu_we = 0;

        host_set(1'b0, 4'b0011, 32'h80, 32'h12345678);
        tick_host();
        host_set(1'b1, 4'h0, 32'h80, 32'h0);
        tick_host();
        tick();

        cpu_re = 1; cpu_addr = 32'h10;
        host_set(1'b1, 4'h0, 32'h20, 32'h0);
        tick_host();
        cpu_re = 0;
        tick_host();
        tick();

        cpu_re = 1; cpu_addr = 32'h30;
        host_set(1'b1, 4'h0, 32'h24, 32'h0);
        for (int i = 0; i < 5; i++) tick_host();
        chk("starve_served", 32'(host_req), 32'd0);

        host_set(1'b0, 4'hF, 32'h28, 32'hCAFEF00D);
        tick_host();
        tick_host();
        host_req = 0;
        tick();
        host_req = 1;
        for (int i = 0; i < 5; i++) tick_host();
        cpu_re = 0;

        host_set(1'b1, 4'h0, 32'h80, 32'h0);
        tick_host();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();

        for (int i = 0; i < 4; i++) begin
            host_set(1'b0, 4'hF, 32'h100 + 32'(i*4), $urandom);
            tick_host();
        end
        for (int i = 0; i < 4; i++) begin
            host_set(1'b1, 4'h0, 32'h100 + 32'(i*4), 32'h0);
            tick_host();
        end
        tick();

        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            cpu_re      = ($urandom_range(0, 2) == 0);
            cpu_we      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            cpu_addr    = {22'd0, 8'($urandom), 2'b00};
            cpu_wr_data = $urandom;
            if (!host_req && $urandom_range(0, 1) == 0)
                host_set(1'($urandom), 4'($urandom),
                         {22'd0, 8'($urandom), 2'b00}, $urandom);
            else if (host_req && !forced && $urandom_range(0, 59) == 0)
                host_req = 0;
            tick();
            if (g_last || !rst_n) host_req = 0;
        end

        rst_n = 1; cpu_re = 0; cpu_we = 0; host_req = 0;
        tick();
        tick();
        @(negedge clk);
        #1;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the four byte-lane data memory banks between two requesters: the CPU execution stage and a host/debug port (program loader, DMA, test access).
- The CPU has fixed priority. The host gets any cycle in which the CPU makes no access.
- A starvation counter forces a one-cycle CPU stall so that a waiting host request always completes.
- The block sits between the execution stage store/load logic and the dmem bank instances.

Parameters:
- ADDR_W, 32, width of the memory-relative address (the 0x10000 base is already removed by the requester).
- STARVE_LIMIT, 8, number of consecutive denied host cycles before a forced grant; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cpu_re  in  1  CPU load access this cycle
- cpu_we  in  4  CPU byte-lane write enables
- cpu_addr  in  ADDR_W  CPU memory address
- cpu_wr_data  in  32  CPU store data, already lane-aligned
- cpu_rd_data  out  32  read data for the CPU
- cpu_stall  out  1  CPU must hold its current instruction this cycle
- host_req  in  1  host access request; held until host_ack
- host_rd  in  1  host access is a read (1) or write (0)
- host_we  in  4  host byte-lane write enables (ignored when host_rd=1)
- host_addr  in  ADDR_W  host memory address
- host_wr_data  in  32  host store data, lane-aligned
- host_ack  out  1  one-cycle pulse: host access issued this cycle
- host_rd_valid  out  1  host read data valid this cycle
- host_rd_data  out  32  host read data
- mem_we  out  4  to dmem banks 3..0
- mem_addr  out  ADDR_W  to dmem banks
- mem_wr_data  out  32  to dmem banks, byte i drives bank i
- mem_rd_data  in  32  from dmem banks; synchronous, valid the cycle after the address

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, wait_cnt=0, last_host_rd=0, cpu_stall=0.
- While rst_n=0, host_ack=0, host_rd_valid=0, host_rd_data=0 and mem_we=0.
- cpu_active = cpu_re | (|cpu_we).
- States:
  - IDLE: no pending host request.
  - WAIT: host_req=1 and denied at least once; wait_cnt counts denied cycles.
  - FORCE: cpu_stall=1 (registered output); the host owns memory this cycle unconditionally.
- Grant rule:
  - In IDLE or WAIT with host_req=1 and cpu_active=0: the host is granted, host_ack=1 combinationally, mem_* driven from host_*, mem_we=0 if host_rd=1.
  - Next state is IDLE and wait_cnt clears.
- Denial:
  - host_req=1 and cpu_active=1: CPU drives mem_*; wait_cnt increments and the state goes to WAIT.
  - When the incremented wait_cnt equals STARVE_LIMIT, the next state is FORCE.
- FORCE:
  - host_ack=1; mem_* comes from host_*; the CPU request is ignored and the CPU re-presents it next cycle because cpu_stall=1.
  - Next state is IDLE with wait_cnt=0. FORCE always lasts exactly one cycle.
- If host_req drops while in WAIT (protocol violation), return to IDLE and clear wait_cnt. No access is issued.
- No host request: CPU fields pass straight to mem_*. With cpu_active=0 and no host request, mem_we=0 and mem_addr=cpu_addr.
- Read return:
  - last_host_rd is registered = (host granted AND host_rd).
  - The next cycle, host_rd_valid=last_host_rd and host_rd_data=mem_rd_data when valid, else 0.
  - cpu_rd_data = mem_rd_data always; the CPU only samples it the cycle after its own load.
- Back-to-back host accesses are allowed on consecutive idle CPU cycles; read latency is 1 cycle after host_ack.
- cpu_stall depends only on state, never combinationally on inputs.
- Reset asserted mid-operation: the pending host request is dropped without ack, a pending read returns no valid, and the state returns to IDLE.

Test Plan:
- Reset: hold rst_n=0 while host_req=1 and cpu_we=4'hF -> mem_we=0, host_ack=0, cpu_stall=0. Release -> CPU write of 0xDEADBEEF to addr 0x40 with all lanes -> mem_we=4'hF, mem_wr_data=0xDEADBEEF the same cycle.
- Idle grant:
  - CPU idle, host write 0x12345678 at addr 0x80 with we=4'b0011 -> host_ack in the same cycle, mem_we=4'b0011.
  - Then a host read of 0x80 -> host_ack, and the next cycle host_rd_valid=1 with host_rd_data=0x00005678 (banks pre-zeroed).
- Priority: CPU load at 0x10 and host read at 0x20 in the same cycle -> mem_addr=0x10, host_ack=0. Next cycle CPU idle -> host_ack=1, mem_addr=0x20.
- Starvation, STARVE_LIMIT=3: cpu_re held high continuously and host_req high -> host denied 3 cycles; 4th cycle cpu_stall=1, host_ack=1, mem_addr=host_addr; 5th cycle cpu_stall=0 and the CPU is served.
- Withdrawal and reset:
  - host_req deasserted in WAIT -> no ack and wait_cnt returns to 0; a later request needs a full STARVE_LIMIT of denials before FORCE.
  - Reset pulsed the cycle after a host read grant -> host_rd_valid stays 0.
- Throughput: 4 consecutive host reads with CPU idle -> 4 acks on consecutive cycles, 4 host_rd_valid pulses each offset by one cycle, data matching preloaded words.
